// File: rtl/alu_pkg.sv
// Shared encodings for the ALU-control decode stage: alucontrol values,
// main-decoder aluop classes, R-type funct codes and the stage FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_BLT  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_LI   = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULT = 4'b1101;
  localparam logic [3:0] ALU_MIX  = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;

  localparam logic [2:0] AOP_ADD = 3'b000;
  localparam logic [2:0] AOP_SUB = 3'b001;
  localparam logic [2:0] AOP_LUI = 3'b011;
  localparam logic [2:0] AOP_BLT = 3'b110;
  localparam logic [2:0] AOP_LI  = 3'b111;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_MIX  = 6'b110011;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_MC   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between ID (master) and the decode stage (slave);
// the EX-side out_* signals travel in the same bundle.
interface alu_decode_stage_if #(
  parameter int FUNCT_W = 6,
  parameter int AOP_W   = 3,
  parameter int CTRL_W  = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [AOP_W-1:0]   aluop;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alucontrol;
  logic               illegal;
  logic               multicycle;
  logic               busy;

  modport master (
    output in_valid, aluop, funct, out_ready,
    input  in_ready, out_valid, alucontrol, illegal, multicycle, busy
  );

  modport slave (
    input  in_valid, aluop, funct, out_ready,
    output in_ready, out_valid, alucontrol, illegal, multicycle, busy
  );
endinterface

// File: rtl/alu_decode_stage_tbl.sv
// Pure combinational ALU-control table: {aluop, funct} -> {alucontrol, illegal, mc}.
// Unknown R-type funct yields alucontrol 0 with illegal set, never X.
module alu_decode_tbl
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int AOP_W   = 3,
  parameter int CTRL_W  = 4
) (
  input  logic [AOP_W-1:0]   i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic               o_illegal,
  output logic               o_mc
);

  // fixed-class aluops first, everything else falls through to the funct table
  always_comb begin
    o_ctrl    = CTRL_W'(ALU_AND);
    o_illegal = 1'b0;
    o_mc      = 1'b0;
    case (i_aluop)
      AOP_W'(AOP_ADD): o_ctrl = CTRL_W'(ALU_ADD);
      AOP_W'(AOP_SUB): o_ctrl = CTRL_W'(ALU_SUB);
      AOP_W'(AOP_LUI): o_ctrl = CTRL_W'(ALU_LUI);
      AOP_W'(AOP_BLT): o_ctrl = CTRL_W'(ALU_BLT);
      AOP_W'(AOP_LI):  o_ctrl = CTRL_W'(ALU_LI);
      default: begin
        case (i_funct)
          FUNCT_W'(F_ADD): o_ctrl = CTRL_W'(ALU_ADD);
          FUNCT_W'(F_SUB): o_ctrl = CTRL_W'(ALU_SUB);
          FUNCT_W'(F_AND): o_ctrl = CTRL_W'(ALU_AND);
          FUNCT_W'(F_OR):  o_ctrl = CTRL_W'(ALU_OR);
          FUNCT_W'(F_SLT): o_ctrl = CTRL_W'(ALU_SLT);
          FUNCT_W'(F_NOR): o_ctrl = CTRL_W'(ALU_NOR);
          FUNCT_W'(F_SLL): o_ctrl = CTRL_W'(ALU_SLL);
          FUNCT_W'(F_MIX): o_ctrl = CTRL_W'(ALU_MIX);
          FUNCT_W'(F_MULT): begin
            o_ctrl = CTRL_W'(ALU_MULT);
            o_mc   = 1'b1;
          end
          FUNCT_W'(F_DIV): begin
            o_ctrl = CTRL_W'(ALU_DIV);
            o_mc   = 1'b1;
          end
          default: begin
            o_ctrl    = CTRL_W'(ALU_AND);
            o_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU-control decode stage between ID and EX with valid/ready
// handshake and mult/div stall sequencing. Optional ALU_DECODE_PERF_EN adds perf counters.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int AOP_W   = 3,
  parameter int CTRL_W  = 4,
  parameter int MC_LAT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  alu_decode_stage_if.slave  bus
`ifdef ALU_DECODE_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_illegal;
  logic                r_mc;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_load;
  logic                w_out_valid;
  logic [CTRL_W-1:0]   w_tbl_ctrl;
  logic                w_tbl_illegal;
  logic                w_tbl_mc;

  alu_decode_tbl #(
    .FUNCT_W (FUNCT_W),
    .AOP_W   (AOP_W),
    .CTRL_W  (CTRL_W)
  ) u_tbl (
    .i_aluop   (bus.aluop),
    .i_funct   (bus.funct),
    .o_ctrl    (w_tbl_ctrl),
    .o_illegal (w_tbl_illegal),
    .o_mc      (w_tbl_mc)
  );

  // ready per state; in S_OUT a slot frees only when EX takes the held op
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_OUT:   w_in_ready = bus.out_ready;
      S_MC:    w_in_ready = 1'b0;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // next state, countdown and load enable
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_OUT: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_tbl_mc) begin
            w_state_nxt = S_MC;
            w_cnt_nxt   = CNT_W'(MC_LAT - 1);
          end else begin
            w_state_nxt = S_OUT;
          end
        end else if (r_state == S_OUT && !bus.out_ready) begin
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_OUT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // state, countdown and output registers; flush drops whatever is held
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_mc      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_ctrl    <= w_tbl_ctrl;
        r_illegal <= w_tbl_illegal;
        r_mc      <= w_tbl_mc;
      end
    end
  end

  assign w_out_valid    = (r_state == S_OUT);
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = (r_state == S_MC);
  assign bus.alucontrol = r_ctrl;
  assign bus.illegal    = r_illegal;
  assign bus.multicycle = r_mc;

`ifdef ALU_DECODE_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  // counters survive flush and wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ops   <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_out_valid && bus.out_ready) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if (bus.in_valid && !w_in_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed scenarios then random traffic,
// checked against a table-driven reference model with per-op presentation deadlines.
module tb_alu_decode_stage;

  localparam int MC_LAT = 4;

  logic clk;
  logic reset;
  logic flush;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;

  alu_decode_stage_if #(.FUNCT_W(6), .AOP_W(3), .CTRL_W(4)) bus ();

`ifdef ALU_DECODE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  alu_decode_stage #(.FUNCT_W(6), .AOP_W(3), .CTRL_W(4), .MC_LAT(MC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef ALU_DECODE_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    logic       mc;
    int         due;
    bit         seen;
  } exp_t;

  exp_t q[$];
  int unsigned fixed_tab[int unsigned];
  int unsigned rtype_tab[int unsigned];
  int m_ops;
  int m_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: value = alucontrol | (mc << 4), straight from the decode table.
  function automatic exp_t model(input logic [2:0] aop, input logic [5:0] f, input int now);
    exp_t e;
    int unsigned v;
    e.ill = 1'b0;
    e.seen = 1'b0;
    if (fixed_tab.exists(int'(aop))) v = fixed_tab[int'(aop)];
    else if (rtype_tab.exists(int'(f))) v = rtype_tab[int'(f)];
    else begin v = 0; e.ill = 1'b1; end
    e.ctrl = v[3:0];
    e.mc = v[4];
    e.due = now + (e.mc ? MC_LAT + 1 : 1);
    return e;
  endfunction

  // Stimulus-side observer: records accepted ops and perf events.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      q.delete();
      m_ops = 0;
      m_stall = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) m_ops++;
      if (bus.in_valid && !bus.in_ready) m_stall++;
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.aluop, bus.funct, cyc));
    end
  end

  // Monitor: compares DUT state/output against the oldest outstanding op.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        check("idle_out_valid", bus.out_valid, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_in_ready", bus.in_ready, 1'b1);
      end else if (cyc < q[0].due) begin
        check("mc_out_valid", bus.out_valid, 1'b0);
        check("mc_busy", bus.busy, 1'b1);
        check("mc_in_ready", bus.in_ready, 1'b0);
      end else begin
        check("out_valid", bus.out_valid, 1'b1);
        if (bus.out_valid) begin
          if (!q[0].seen) begin
            check("latency", cyc, q[0].due);
            q[0].seen = 1'b1;
          end
          check("alucontrol", bus.alucontrol, q[0].ctrl);
          check("illegal", bus.illegal, q[0].ill);
          check("multicycle", bus.multicycle, q[0].mc);
          check("out_busy", bus.busy, 1'b0);
          check("out_in_ready", bus.in_ready, bus.out_ready);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] aop, input logic [5:0] f);
    bus.in_valid = 1'b1;
    bus.aluop = aop;
    bus.funct = f;
  endtask

  logic [5:0] legal_f [10];

  initial begin
    fixed_tab[0] = 32'h02; fixed_tab[1] = 32'h06; fixed_tab[3] = 32'h0B;
    fixed_tab[6] = 32'h05; fixed_tab[7] = 32'h09;
    rtype_tab[32] = 32'h02; rtype_tab[34] = 32'h06; rtype_tab[36] = 32'h00;
    rtype_tab[37] = 32'h01; rtype_tab[42] = 32'h07; rtype_tab[39] = 32'h0C;
    rtype_tab[0]  = 32'h08; rtype_tab[51] = 32'h0E; rtype_tab[24] = 32'h1D;
    rtype_tab[26] = 32'h1F;
    legal_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd51, 6'd24, 6'd26};

    checks = 0; failures = 0; cyc = 0; mon_en = 1'b0;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.aluop = 3'd0; bus.funct = 6'd0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_alucontrol", bus.alucontrol, 4'h0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_multicycle", bus.multicycle, 1'b0);
    mon_en = 1'b1;

    // back-to-back R-type stream
    step();
    bus.out_ready = 1'b1;
    issue(3'b010, 6'b100000); step();
    issue(3'b010, 6'b100100); step();
    issue(3'b010, 6'b100111); step();
    bus.in_valid = 1'b0; step(); step();

    // multi-cycle mult
    issue(3'b010, 6'b011000); step();
    bus.in_valid = 1'b0;
    repeat (MC_LAT + 2) step();

    // EX backpressure holds the op
    bus.out_ready = 1'b0;
    issue(3'b001, 6'b000000); step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    bus.out_ready = 1'b1; step(); step();

    // illegal funct, then flush in the middle of a div
    issue(3'b010, 6'b111111); step();
    bus.in_valid = 1'b0; step(); step();
    issue(3'b100, 6'b011010); step();
    bus.in_valid = 1'b0; step();
    flush = 1'b1; issue(3'b000, 6'b000000); step();
    flush = 1'b0; bus.in_valid = 1'b0; step(); step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.aluop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) bus.funct = legal_f[$urandom_range(0, 9)];
      else bus.funct = 6'($urandom_range(0, 63));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end

    // drain and final checks
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (MC_LAT + 4) step();
    @(negedge clk);
    #2;
    check("drain_queue_empty", q.size(), 0);
`ifdef ALU_DECODE_PERF_EN
    check("perf_ops", perf_ops, m_ops);
    check("perf_stall", perf_stall, m_stall);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
